// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine transaction controller.
// Holds the controller state enum, coin values and the default price/credit cap.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_e;

  localparam int unsigned COIN5_JIAO         = 5;
  localparam int unsigned COIN10_JIAO        = 10;
  localparam int unsigned PRICE_DEFAULT      = 25;
  localparam int unsigned CREDIT_MAX_DEFAULT = 50;

endpackage

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter with an expiry indication.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load_i       - load load_val_i into the counter (wins over counting)
//   load_val_i   - value loaded; done_c asserts after load_val_i enabled cycles
//   en_i         - count down while high
//   done_c       - combinational: enabled and counter has reached zero
module vend_cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  // Counter register; saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = en_i & (cnt_q == '0);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending machine transaction controller: accumulates credit from debounced
// coin pulses, handles buy/cancel, times the dispense pulse and issues change.
// Optional feature: define VEND_TIMEOUT_EN to refund credit after
// TIMEOUT_CYCLES cycles of inactivity in COLLECT.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   coin5_flag, coin10_flag  - coin inserted pulses (5 / 10 jiao)
//   buy_flag, cancel_flag    - button pulses
//   credit                   - current credit in jiao
//   dispense                 - actuator drive, DISP_CYCLES cycles per sale
//   change, change_vld       - refund amount and its one-cycle strobe
//   reject                   - one-cycle refusal pulse
//   busy                     - high while dispensing or paying change
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CW          = 8,
  parameter int unsigned PRICE       = PRICE_DEFAULT,
  parameter int unsigned CREDIT_MAX  = CREDIT_MAX_DEFAULT,
  parameter int unsigned DISP_CYCLES = 50_000_000
`ifdef VEND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin5_flag,
  input  logic          coin10_flag,
  input  logic          buy_flag,
  input  logic          cancel_flag,
  output logic [CW-1:0] credit,
  output logic          dispense,
  output logic [CW-1:0] change,
  output logic          change_vld,
  output logic          reject,
  output logic          busy
);

  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned DW  = $clog2(DISP_CYCLES + 1);

  vend_state_e   state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] change_q, change_d;
  logic          chg_vld_q, chg_vld_d;
  logic          reject_q, reject_d;
  logic          disp_q, busy_q;

  logic          win_c10_c, win_c5_c, coin_win_c, lost_coin_c;
  logic [CW-1:0] coin_val_c;
  logic [CW:0]   sum_c;
  logic          disp_load_c, disp_done_c;

  // Arbitration: cancel > buy > coin10 > coin5; losing coins are refused.
  assign win_c10_c   = coin10_flag & ~cancel_flag & ~buy_flag;
  assign win_c5_c    = coin5_flag & ~cancel_flag & ~buy_flag & ~coin10_flag;
  assign coin_win_c  = win_c10_c | win_c5_c;
  assign lost_coin_c = (coin10_flag & ~win_c10_c) | (coin5_flag & ~win_c5_c);
  assign coin_val_c  = win_c10_c ? CW'(COIN10_JIAO) : CW'(COIN5_JIAO);
  assign sum_c       = {1'b0, credit_q} + {1'b0, coin_val_c};

  // Dispense interval: loaded with DISP_CYCLES-1 on the accepted buy, so
  // the state leaves DISPENSE on the DISP_CYCLES-th edge after entry.
  vend_cycle_timer #(.W(DW)) u_disp_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (disp_load_c),
    .load_val_i (DW'(DISP_CYCLES - 1)),
    .en_i       (state_q == DISPENSE),
    .done_c     (disp_done_c)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic tmo_load_c, tmo_done_c;

  // Inactivity timer restarts on any flag and whenever not collecting.
  assign tmo_load_c = (state_q != COLLECT) | coin5_flag | coin10_flag |
                      buy_flag | cancel_flag;

  vend_cycle_timer #(.W(TW)) u_tmo_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmo_load_c),
    .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
    .en_i       (state_q == COLLECT),
    .done_c     (tmo_done_c)
  );
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    change_d    = change_q;
    chg_vld_d   = 1'b0;
    reject_d    = lost_coin_c;
    disp_load_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coin_win_c) begin
          credit_d = coin_val_c;
          state_d  = COLLECT;
        end else if (buy_flag && !cancel_flag) begin
          reject_d = 1'b1;
        end
      end

      COLLECT: begin
        if (cancel_flag) begin
          change_d  = credit_q;
          chg_vld_d = 1'b1;
          credit_d  = '0;
          state_d   = CHANGE;
        end else if (buy_flag) begin
          if (credit_q >= CW'(PRICE)) begin
            credit_d    = credit_q - CW'(PRICE);
            disp_load_c = 1'b1;
            state_d     = DISPENSE;
          end else begin
            reject_d = 1'b1;
          end
        end else if (coin_win_c) begin
          if (sum_c <= CW1'(CREDIT_MAX)) begin
            credit_d = sum_c[CW-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_done_c) begin
          change_d  = credit_q;
          chg_vld_d = 1'b1;
          credit_d  = '0;
          state_d   = CHANGE;
        end
`endif
      end

      DISPENSE: begin
        reject_d = coin5_flag | coin10_flag;
        if (disp_done_c) begin
          if (credit_q != '0) begin
            change_d  = credit_q;
            chg_vld_d = 1'b1;
            credit_d  = '0;
            state_d   = CHANGE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      CHANGE: begin
        reject_d = coin5_flag | coin10_flag;
        credit_d = '0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      change_q  <= '0;
      chg_vld_q <= 1'b0;
      reject_q  <= 1'b0;
      disp_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      change_q  <= change_d;
      chg_vld_q <= chg_vld_d;
      reject_q  <= reject_d;
      disp_q    <= (state_d == DISPENSE);
      busy_q    <= (state_d == DISPENSE) || (state_d == CHANGE);
    end
  end

  assign credit     = credit_q;
  assign dispense   = disp_q;
  assign change     = change_q;
  assign change_vld = chg_vld_q;
  assign reject     = reject_q;
  assign busy       = busy_q;

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller for the vending machine. It sits directly downstream of the per-button key debouncers and consumes their one-cycle `flag` pulses for coin 0.5, coin 1, buy and cancel. From those pulses it accumulates credit, accepts or refuses coins, runs the dispense interval and returns change. Its outputs drive the credit display, the dispense actuator and the change hopper.

## Interface
Parameters:
- `CW`, 8: width of credit and change values, in jiao (0.1 yuan).
- `PRICE`, 25: item price in jiao.
- `CREDIT_MAX`, 50: maximum credit that may be held, in jiao.
- `DISP_CYCLES`, 50_000_000: duration of the dispense pulse, in clk cycles (1 s at 50 MHz).
- `TIMEOUT_CYCLES`, 500_000_000: inactivity refund limit. Used only with `VEND_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `coin5_flag`  in  1  one-cycle pulse: a 0.5 yuan coin was inserted (5 jiao).
- `coin10_flag`  in  1  one-cycle pulse: a 1 yuan coin was inserted (10 jiao).
- `buy_flag`  in  1  one-cycle pulse: buy button pressed.
- `cancel_flag`  in  1  one-cycle pulse: cancel/refund button pressed.
- `credit`  out  CW  current credit in jiao.
- `dispense`  out  1  dispense actuator drive; high for exactly `DISP_CYCLES` cycles per sale.
- `change`  out  CW  change/refund amount in jiao; qualified by `change_vld`.
- `change_vld`  out  1  one-cycle pulse: hopper must pay out `change`.
- `reject`  out  1  one-cycle pulse: coin refused, or buy refused for insufficient credit.
- `busy`  out  1  high in DISPENSE and CHANGE.

## Operation
- States are IDLE, COLLECT, DISPENSE and CHANGE. Reset puts the block in IDLE with every output at 0.
- Per-cycle event priority is cancel > buy > coin10 > coin5. Only the winning event is processed. A coin that loses arbitration is refused and pulses `reject`. A losing buy or cancel is dropped silently.
- **IDLE:** a coin takes `credit <= value` and moves to COLLECT. Buy pulses `reject`. Cancel is ignored.
- **COLLECT, coins:** a coin is accepted if `credit + value <= CREDIT_MAX`, giving `credit += value`. Otherwise `reject` pulses and `credit` is unchanged. Compute the sum at CW+1 bits so it cannot wrap.
- **COLLECT, buy:** if `credit >= PRICE`, then `credit -= PRICE` and the state moves to DISPENSE. If `credit < PRICE`, `reject` pulses and the state stays in COLLECT.
- **COLLECT, cancel:** moves to CHANGE with the full credit as refund.
- **DISPENSE:** `dispense` is high. Every input is ignored, and any coin pulse pulses `reject`. After `DISP_CYCLES` cycles the state moves to CHANGE if `credit > 0`, otherwise to IDLE.
- **CHANGE:** lasts exactly one cycle. In that cycle `change_vld` is 1 and `change` equals the credit. The next state is IDLE with `credit = 0`. `change` holds its value until the next CHANGE. Inputs arriving in CHANGE are treated as in DISPENSE.
- **Reset mid-operation:** the transaction is abandoned, `dispense` drops, and no change is issued.

## Timing
- All outputs are registered. An event accepted on the clk edge where its flag is high becomes visible one cycle later.
- `reject` is high in the cycle after the refused flag.
- `dispense` goes high the cycle after the accepted `buy_flag` and stays high for exactly `DISP_CYCLES` cycles. The dispense counter is `$clog2(DISP_CYCLES+1)` bits.
- `change_vld` is high in the cycle immediately following the last `dispense` cycle. For a cancel, it is high in the cycle after `cancel_flag`.
- `credit` reads 0 in the same cycle that `change_vld` is high.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An inactivity counter runs only in COLLECT. It clears on any input flag.
  - When it reaches `TIMEOUT_CYCLES`, the state moves to CHANGE and the full credit is refunded.
- `VEND_TIMEOUT_EN` undefined: COLLECT holds credit indefinitely. The counter and `TIMEOUT_CYCLES` logic are absent.

## Structure
- Shared package `vend_pkg` holds:
  - the state enum (IDLE, COLLECT, DISPENSE, CHANGE);
  - the coin value constants `COIN5_JIAO = 5` and `COIN10_JIAO = 10`;
  - the default `PRICE` and `CREDIT_MAX`.
- One sub-module, `vend_cycle_timer`: a loadable down-counter with a `done` pulse. It is instantiated for the dispense interval, and for the inactivity timeout when `VEND_TIMEOUT_EN` is defined.

## Test plan
Run with `DISP_CYCLES` = 4.
- **Exact price sale:** coin10, coin10, coin5, buy.
  - `credit` goes 10, 20, 25, 0.
  - `dispense` is high for 4 cycles; no `change_vld`; back to IDLE.
- **Overpay:** coin10 ×3, buy.
  - Required: `dispense` for 4 cycles, then `change_vld` with `change = 5`.
- **Cap:** coin10 ×5 → `credit = 50`.
  - A further coin5 pulses `reject`; `credit` stays 50.
  - Cancel → `change_vld` with `change = 50`.
- **Simultaneous events:** coin10 and coin5 in the same cycle from IDLE.
  - Required: `credit = 10` and one `reject`.
  - Then cancel and buy together with credit 30 → refund of 30, no `dispense`.
- **Insufficient and busy:**
  - Buy at credit 20 → `reject`; `credit` stays 20.
  - Coin during DISPENSE → `reject`; `credit` unchanged.
- **Reset and timeout:**
  - `rst` mid-DISPENSE: all outputs are 0 the next cycle and no `change_vld` follows.
  - With `VEND_TIMEOUT_EN` and `TIMEOUT_CYCLES = 8`: credit 15, then idle for 8 cycles → `change_vld` with `change = 15`.
